ps2_paddle_keys: RTL and testbench
==================================

// Module: ps2_paddle_keys
// PURPOSE
//  PS/2 keyboard receiver and key-state decoder that feeds the paddle controls in pong.
//  - Receives device-to-host PS/2 frames and decodes set-2 make/break scan codes.
//  - Outputs held-key levels: W/S drive the left paddle, Up/Down arrows drive the right paddle.
//  - Sits between the top-level ps2_clk/ps2_data pins and the paddle up/down inputs.
//  - Receive-only: never drives the PS/2 lines.
// PARAMETERS
//  TIMEOUT_CYCLES  200_000  clk cycles without a PS/2 falling edge before a partial frame is aborted (2 ms @ 100 MHz)
//  SYNC_STAGES     2        flip-flop synchroniser depth on ps2_clk and ps2_data (min 2)
// PORTS
//  clk         in   1  100 MHz system clock
//  reset       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS/2 clock from the pin (asynchronous)
//  ps2_data    in   1  raw PS/2 data from the pin (asynchronous)
//  left_up     out  1  left paddle up (W held, S not held)
//  left_down   out  1  left paddle down (S held, W not held)
//  right_up    out  1  right paddle up (Up arrow held, Down arrow not held)
//  right_down  out  1  right paddle down (Down arrow held, Up arrow not held)
//  rx_byte     out  8  last good received byte
//  rx_valid    out  1  one-cycle strobe: rx_byte has been updated
//  frame_err   out  1  one-cycle strobe: parity error, stop-bit error, or timeout
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - All outputs 0, rx_byte=8'h00.
//   - Synchronisers, FSM, shift register, timeout counter, prefix flags and key states cleared.
//   - A reset in the middle of a frame discards the partial frame; no strobe is issued.
//  Synchronisation and edge detection:
//   - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
//   - A falling edge is (previous synced clk = 1) && (current synced clk = 0).
//   - Data is sampled only on that edge.
//  Frame: start(0), D0..D7 (LSB first), parity (odd), stop(1).
//  Framer FSM:
//   - IDLE: on an edge, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE (glitch, no error).
//   - DATA: shift in one bit per edge; after the 8th bit go to PARITY.
//   - PARITY: capture the parity bit; go to STOP.
//   - STOP: on an edge, check stop=1 and XOR(D7..D0,P)=1.
//     - Pass: in the next clk, rx_byte<=data and rx_valid=1 for one cycle.
//     - Fail: in the next clk, frame_err=1 for one cycle; the byte is dropped and rx_byte is unchanged.
//     - In both cases return to IDLE.
//  Timeout:
//   - The counter resets on every edge and in IDLE.
//   - In any state other than IDLE, reaching TIMEOUT_CYCLES-1 causes: IDLE, frame_err pulse, ext/brk cleared.
//  Decoder (acts in the same cycle rx_valid is high; all outputs are registered):
//   - Byte E0: ext<=1.
//   - Byte F0: brk<=1.
//   - Any other byte: look up {ext,byte}. On a hit, key_state<=~brk. Then clear ext and brk.
//   - Key map:
//     - {0,1D}=W
//     - {0,1B}=S
//     - {1,75}=Up
//     - {1,72}=Down
//   - Unmapped codes only clear ext and brk.
//   - Typematic repeat (a repeated make) is idempotent.
//  Outputs:
//   - left_up=W&~S, left_down=S&~W; same rule on the right with Up/Down.
//   - Both keys of a pair held -> both outputs 0.
//   - Key outputs change in the same cycle as rx_valid for the completing byte (latency 1 clk after the stop-bit edge is detected).
//  Widths:
//   - Bit counter is 3 bits.
//   - Timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates (never wraps).
// STRUCTURE
//  - pong_pkg: scan-code localparams SC_EXT=8'hE0, SC_BRK=8'hF0, SC_W=8'h1D, SC_S=8'h1B, SC_UP=8'h75, SC_DN=8'h72; framer state encoding.
//  - Sub-module ps2_rx_frame: synchroniser, edge detect, framer FSM and timeout. Outputs rx_byte, rx_valid, frame_err.
//  - The decoder and key-state registers live in ps2_paddle_keys itself.
// TESTING
//  Bench drives PS/2 at ~12.5 kHz, data changing at clk high.
//  1. Frame 0x1D (parity 1) -> one rx_valid pulse, rx_byte=1D, left_up=1, all other key outputs 0, frame_err never asserted.
//  2. Then F0,1D -> rx_valid twice, left_up=0 after the second byte; E0,75 -> right_up=1; E0,F0,75 -> right_up=0.
//  3. 0x1B sent with parity 0 -> frame_err pulse, no rx_valid, rx_byte keeps its prior value, left_down stays 0.
//  4. Start bit plus 4 data bits, then clk idle for more than 200_000 cycles -> one frame_err pulse; the following good 0x1B gives left_down=1.
//  5. W make then S make -> left_up=0, left_down=0; S break -> left_up=1, left_down=0.
//  6. reset=0 asserted mid-frame after W is held -> all outputs 0 immediately; after release, a complete 0x72 frame leaves right_down=0 (E0 prefix was lost).

Source files
------------

// File: rtl/ps2_paddle_keys_pkg.sv
// Shared constants for the PS/2 paddle-key receiver: set-2 scan codes, framer
// state encoding, key-slot indices and the scan-code-to-key lookup.
package ps2_paddle_keys_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_W   = 8'h1D;
    localparam logic [7:0] SC_S   = 8'h1B;
    localparam logic [7:0] SC_UP  = 8'h75;
    localparam logic [7:0] SC_DN  = 8'h72;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Key slots are laid out as {down, up} pairs so pair n occupies bits 2n+1:2n.
    localparam int KEY_W    = 0;
    localparam int KEY_S    = 1;
    localparam int KEY_UP   = 2;
    localparam int KEY_DN   = 3;
    localparam int NUM_KEYS = 4;
    localparam int NUM_PAIRS = NUM_KEYS / 2;

    typedef struct packed {
        logic ext;
        logic brk;
    } prefix_t;

    function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        case ({ext, code})
            {1'b0, SC_W}:  mask[KEY_W]  = 1'b1;
            {1'b0, SC_S}:  mask[KEY_S]  = 1'b1;
            {1'b1, SC_UP}: mask[KEY_UP] = 1'b1;
            {1'b1, SC_DN}: mask[KEY_DN] = 1'b1;
            default:       mask = '0;
        endcase
        return mask;
    endfunction

    function automatic logic frame_good(input logic [7:0] data, input logic parity, input logic stop);
        return stop & (^{data, parity});
    endfunction

endpackage

// File: rtl/ps2_paddle_keys_if.sv
// PS/2 pin inputs plus the decoded paddle levels and receive strobes.
interface ps2_paddle_keys_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic       left_up;
    logic       left_down;
    logic       right_up;
    logic       right_down;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output left_up,
        output left_down,
        output right_up,
        output right_down,
        output rx_byte,
        output rx_valid,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  left_up,
        input  left_down,
        input  right_up,
        input  right_down,
        input  rx_byte,
        input  rx_valid,
        input  frame_err
    );

endinterface

// File: rtl/ps2_paddle_keys_rx_frame.sv
// PS/2 device-to-host framer: pin synchronisers, falling-edge detect, 11-bit
// frame FSM with odd-parity/stop checking and an inter-edge timeout.
module ps2_paddle_keys_rx_frame
    import ps2_paddle_keys_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       byte_ok,
    output logic [7:0] byte_data,
    output logic       timeout_hit
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic [1:0]             state_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             shift_reg;
    logic                   parity_reg;
    logic [CNT_W-1:0]       to_cnt_reg;
    logic [7:0]             rx_byte_reg;
    logic                   rx_valid_reg;
    logic                   frame_err_reg;

    logic clk_cur;
    logic data_cur;
    logic fall;
    logic stop_edge;
    logic stop_bad;

    assign clk_cur  = clk_sync_reg[SYNC_STAGES-1];
    assign data_cur = data_sync_reg[SYNC_STAGES-1];
    assign fall     = clk_prev_reg & ~clk_cur;

    // Completion and timeout are exposed combinationally so the key decoder can
    // update on the same edge that raises rx_valid / frame_err.
    assign stop_edge   = fall && (state_reg == ST_STOP);
    assign byte_ok     = stop_edge && frame_good(shift_reg, parity_reg, data_cur);
    assign stop_bad    = stop_edge && !byte_ok;
    assign timeout_hit = (state_reg != ST_IDLE) && !fall && (to_cnt_reg == CNT_LAST);
    assign byte_data   = shift_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_reg  <= '0;
            data_sync_reg <= '0;
            clk_prev_reg  <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            clk_prev_reg  <= clk_cur;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == ST_IDLE) || fall) begin
            to_cnt_reg <= '0;
        end else if (to_cnt_reg != CNT_LAST) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            rx_byte_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_valid_reg  <= byte_ok;
            frame_err_reg <= stop_bad | timeout_hit;
            if (byte_ok) begin
                rx_byte_reg <= shift_reg;
            end
            if (timeout_hit) begin
                state_reg <= ST_IDLE;
            end else if (fall) begin
                case (state_reg)
                    ST_IDLE: begin
                        // A high level here is a glitch, not a start bit.
                        if (!data_cur) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {data_cur, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= ST_PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        parity_reg <= data_cur;
                        state_reg  <= ST_STOP;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_byte   = rx_byte_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard front end for pong: receives set-2 scan codes and turns the
// W/S and Up/Down make/break sequences into held-key paddle levels.
module ps2_paddle_keys
    import ps2_paddle_keys_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clk,
    input  logic                reset,
    ps2_paddle_keys_if.slave    bus
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       byte_ok;
    logic [7:0] byte_data;
    logic       timeout_hit;

    ps2_paddle_keys_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx_frame (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (bus.ps2_clk),
        .ps2_data    (bus.ps2_data),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .byte_ok     (byte_ok),
        .byte_data   (byte_data),
        .timeout_hit (timeout_hit)
    );

    prefix_t               prefix_reg;
    prefix_t               prefix_next;
    logic [NUM_KEYS-1:0]   key_reg;
    logic [NUM_KEYS-1:0]   key_next;
    logic [NUM_KEYS-1:0]   hit_mask;
    logic [NUM_PAIRS-1:0]  up_next;
    logic [NUM_PAIRS-1:0]  down_next;
    logic [NUM_PAIRS-1:0]  up_reg;
    logic [NUM_PAIRS-1:0]  down_reg;

    assign hit_mask = key_mask(prefix_reg.ext, byte_data);

    always_comb begin
        key_next    = key_reg;
        prefix_next = prefix_reg;
        if (byte_ok) begin
            if (byte_data == SC_EXT) begin
                prefix_next.ext = 1'b1;
            end else if (byte_data == SC_BRK) begin
                prefix_next.brk = 1'b1;
            end else begin
                // Unmapped codes give an empty mask, so they only drop the prefixes.
                key_next    = prefix_reg.brk ? (key_reg & ~hit_mask) : (key_reg | hit_mask);
                prefix_next = '0;
            end
        end else if (timeout_hit) begin
            prefix_next = '0;
        end
    end

    // Opposing keys of a pair cancel each other out.
    generate
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
            assign up_next[gi]   = key_next[2*gi]   & ~key_next[2*gi+1];
            assign down_next[gi] = key_next[2*gi+1] & ~key_next[2*gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prefix_reg <= '0;
            key_reg    <= '0;
            up_reg     <= '0;
            down_reg   <= '0;
        end else begin
            prefix_reg <= prefix_next;
            key_reg    <= key_next;
            up_reg     <= up_next;
            down_reg   <= down_next;
        end
    end

    assign bus.left_up    = up_reg[0];
    assign bus.left_down  = down_reg[0];
    assign bus.right_up   = up_reg[1];
    assign bus.right_down = down_reg[1];
    assign bus.rx_byte    = rx_byte;
    assign bus.rx_valid   = rx_valid;
    assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Directed bench for ps2_paddle_keys: table of PS/2 frames with expected
// strobes, byte and paddle levels, plus a hand-written mid-frame reset case.
module tb_ps2_paddle_keys;

    localparam int HALF = 20;   // PS/2 half-period in clk cycles
    localparam int TO   = 200;  // shortened timeout for simulation

    localparam int K_FULL  = 0;
    localparam int K_BADP  = 1;
    localparam int K_TRUNC = 2;

    typedef struct {
        logic [7:0] code;
        int         kind;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_byte;
        logic [3:0] exp_keys;   // {left_up, left_down, right_up, right_down}
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_paddle_keys_if bus();

    ps2_paddle_keys #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         valid_cnt = 0;
    int         err_cnt   = 0;
    logic [3:0] snap_keys = 4'b0;
    wire  [3:0] keys = {bus.left_up, bus.left_down, bus.right_up, bus.right_down};

    // Count strobe cycles and capture key levels in the cycle rx_valid is high.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            snap_keys = keys;
        end
        if (bus.frame_err === 1'b1) begin
            err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] code, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            ps2_bit(code[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_parity);
        send_bits(code, 8);
        ps2_bit((~^code) ^ bad_parity);
        ps2_bit(1'b1);
        repeat (2 * HALF) @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int e0;

        tbl.push_back('{8'h1D, K_FULL,  1, 0, 8'h1D, 4'b1000}); // W make
        tbl.push_back('{8'hF0, K_FULL,  1, 0, 8'hF0, 4'b1000});
        tbl.push_back('{8'h1D, K_FULL,  1, 0, 8'h1D, 4'b0000}); // W break
        tbl.push_back('{8'hE0, K_FULL,  1, 0, 8'hE0, 4'b0000});
        tbl.push_back('{8'h75, K_FULL,  1, 0, 8'h75, 4'b0010}); // Up make
        tbl.push_back('{8'hE0, K_FULL,  1, 0, 8'hE0, 4'b0010});
        tbl.push_back('{8'hF0, K_FULL,  1, 0, 8'hF0, 4'b0010});
        tbl.push_back('{8'h75, K_FULL,  1, 0, 8'h75, 4'b0000}); // Up break
        tbl.push_back('{8'h1B, K_BADP,  0, 1, 8'h75, 4'b0000}); // parity error
        tbl.push_back('{8'h1B, K_TRUNC, 0, 1, 8'h75, 4'b0000}); // timeout
        tbl.push_back('{8'h1B, K_FULL,  1, 0, 8'h1B, 4'b0100}); // S make
        tbl.push_back('{8'hF0, K_FULL,  1, 0, 8'hF0, 4'b0100});
        tbl.push_back('{8'h1B, K_FULL,  1, 0, 8'h1B, 4'b0000}); // S break
        tbl.push_back('{8'h1D, K_FULL,  1, 0, 8'h1D, 4'b1000}); // W make
        tbl.push_back('{8'h1B, K_FULL,  1, 0, 8'h1B, 4'b0000}); // W+S held
        tbl.push_back('{8'h1D, K_FULL,  1, 0, 8'h1D, 4'b0000}); // typematic W
        tbl.push_back('{8'hF0, K_FULL,  1, 0, 8'hF0, 4'b0000});
        tbl.push_back('{8'h1B, K_FULL,  1, 0, 8'h1B, 4'b1000}); // S break
        tbl.push_back('{8'hE0, K_FULL,  1, 0, 8'hE0, 4'b1000});
        tbl.push_back('{8'h72, K_FULL,  1, 0, 8'h72, 4'b1001}); // Down make
        tbl.push_back('{8'hE0, K_FULL,  1, 0, 8'hE0, 4'b1001});
        tbl.push_back('{8'hF0, K_FULL,  1, 0, 8'hF0, 4'b1001});
        tbl.push_back('{8'h72, K_FULL,  1, 0, 8'h72, 4'b1000}); // Down break
        tbl.push_back('{8'hE0, K_FULL,  1, 0, 8'hE0, 4'b1000});
        tbl.push_back('{8'h72, K_TRUNC, 0, 1, 8'hE0, 4'b1000}); // timeout drops E0
        tbl.push_back('{8'h72, K_FULL,  1, 0, 8'h72, 4'b1000}); // plain 72: unmapped

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset keys", 32'(keys), 32'h0);
        check("reset rx_byte", 32'(bus.rx_byte), 32'h0);
        check("reset rx_valid", 32'(bus.rx_valid), 32'h0);
        check("reset frame_err", 32'(bus.frame_err), 32'h0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            case (tbl[i].kind)
                K_FULL:  send_frame(tbl[i].code, 1'b0);
                K_BADP:  send_frame(tbl[i].code, 1'b1);
                default: begin
                    send_bits(tbl[i].code, 4);
                    bus.ps2_data = 1'b1;
                    repeat (2 * TO) @(negedge clk);
                end
            endcase
            check($sformatf("v%0d code %0h rx_valid pulses", i, tbl[i].code), 32'(valid_cnt - v0), 32'(tbl[i].exp_valid));
            check($sformatf("v%0d code %0h frame_err pulses", i, tbl[i].code), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
            check($sformatf("v%0d code %0h rx_byte", i, tbl[i].code), 32'(bus.rx_byte), 32'(tbl[i].exp_byte));
            check($sformatf("v%0d code %0h keys", i, tbl[i].code), 32'(keys), 32'(tbl[i].exp_keys));
            if (tbl[i].exp_valid == 1) begin
                check($sformatf("v%0d code %0h keys with rx_valid", i, tbl[i].code), 32'(snap_keys), 32'(tbl[i].exp_keys));
            end
        end

        // Mid-frame reset with W held and an E0 prefix pending.
        send_frame(8'hE0, 1'b0);
        check("pre-reset rx_byte", 32'(bus.rx_byte), 32'hE0);
        check("pre-reset keys", 32'(keys), 32'b1000);
        send_bits(8'h72, 3);
        v0 = valid_cnt;
        e0 = err_cnt;
        reset = 1'b0;
        #1;
        check("async reset keys", 32'(keys), 32'h0);
        check("async reset rx_byte", 32'(bus.rx_byte), 32'h0);
        repeat (20) @(negedge clk);
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        repeat (2 * TO) @(negedge clk);
        check("reset no rx_valid", 32'(valid_cnt - v0), 32'h0);
        check("reset no frame_err", 32'(err_cnt - e0), 32'h0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h72, 1'b0);
        check("post-reset rx_valid pulses", 32'(valid_cnt - v0), 32'h1);
        check("post-reset frame_err pulses", 32'(err_cnt - e0), 32'h0);
        check("post-reset rx_byte", 32'(bus.rx_byte), 32'h72);
        check("post-reset keys", 32'(keys), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
